// File: rtl/cdc_req_tx.sv
// cdc_req_tx: source side of a four-phase req/ack clock-domain-crossing handshake.
//
// A word accepted on in_valid/in_ready is held on data_out while req_out is
// raised; the far domain's ack_in is brought in through a two-flop synchronizer
// and the return-to-zero phase completes before the next word is accepted.
//
// Ports:
//   CLK, RST  - clock, asynchronous active-high reset
//   in_valid  - local word available
//   in_data   - local word (WIDTH bits)
//   in_ready  - high exactly while idle
//   req_out   - registered request level to the far domain
//   data_out  - registered word, stable whenever req_out is high
//   ack_in    - asynchronous acknowledge level from the far domain
//   done      - one-cycle pulse on normal completion
//   err       - one-cycle pulse on timeout abort
//
// Optional feature: define CDC_TX_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT cycles. Without it err is constant 0 and
// TIMEOUT has no effect.
module cdc_req_tx #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("cdc_req_tx: TIMEOUT must be in 2..65535");
    end

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             sync1_q, ack_s;
    logic             aborted;

`ifdef CDC_TX_TIMEOUT_EN
    logic [15:0]      cnt_q, cnt_d;
    logic             aborted_q, aborted_d;
    assign aborted = aborted_q;
`else
    assign aborted = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                data_d  = in_data;
                req_d   = 1'b1;
                state_d = REQ_HI;
`ifdef CDC_TX_TIMEOUT_EN
                cnt_d     = '0;
                aborted_d = 1'b0;
`endif
            end
            REQ_HI: if (ack_s) begin
                req_d   = 1'b0;
                state_d = REQ_LO;
            end
`ifdef CDC_TX_TIMEOUT_EN
            // ack arriving in the limit cycle takes priority over the abort
            else if (cnt_q == 16'(TIMEOUT - 1)) begin
                req_d     = 1'b0;
                err_d     = 1'b1;
                aborted_d = 1'b1;
                state_d   = REQ_LO;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
`endif
            REQ_LO: if (!ack_s) begin
                state_d = IDLE;
                done_d  = !aborted;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sync1_q <= 1'b0;
            ack_s   <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
            cnt_q     <= '0;
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sync1_q <= ack_in;
            ack_s   <= sync1_q;
`ifdef CDC_TX_TIMEOUT_EN
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
`endif
        end
    end

    assign in_ready = (state_q == IDLE);
    assign req_out  = req_q;
    assign data_out = data_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cdc_req_tx.sv
// tb_cdc_req_tx: scoreboard bench for cdc_req_tx with loopback and manual far side.
module tb_cdc_req_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, req_out, done, err, ack_in;
    logic [7:0] data_out;
    logic       loop = 1'b1;
    logic       ack_man = 1'b0;

    assign ack_in = loop ? req_out : ack_man;

    cdc_req_tx #(.WIDTH(8), .TIMEOUT(10)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req_out(req_out), .data_out(data_out),
        .ack_in(ack_in), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int exp_err_cyc = -1;
    logic       prev_req = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_data", {24'h0, data_out}, {24'h0, e.d});
                    chk("done_cycle", cyc, e.c);
                end
            end
            chk("err", {31'h0, err}, {31'h0, cyc == exp_err_cyc});
            if (req_out && prev_req) chk("data_stable", {24'h0, data_out}, {24'h0, prev_data});
        end
        prev_req  = req_out;
        prev_data = data_out;
    end

    initial begin
        int t0;
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", {31'h0, in_ready}, 1);
        chk("rst_req", {31'h0, req_out}, 0);
        chk("rst_data", {24'h0, data_out}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_err", {31'h0, err}, 0);
        RST = 1'b0;
        @(negedge CLK);

        // loopback single transfer
        t0 = cyc;
        chk("t1_ready", {31'h0, in_ready}, 1);
        in_valid = 1'b1; in_data = 8'hA5;
        q.push_back('{8'hA5, t0 + 7});
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 1) in_valid = 1'b0;
            chk("t1_req", {31'h0, req_out}, {31'h0, k <= 3});
            chk("t1_data", {24'h0, data_out}, 32'hA5);
            chk("t1_ready_k", {31'h0, in_ready}, {31'h0, k == 7});
        end

        // back-to-back with in_valid held high
        t0 = cyc;
        in_valid = 1'b1; in_data = 8'h11;
        q.push_back('{8'h11, t0 + 7});
        q.push_back('{8'h22, t0 + 14});
        @(negedge CLK);
        in_data = 8'h22;
        repeat (6) @(negedge CLK);
        chk("b2b_ready7", {31'h0, in_ready}, 1);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("b2b_req8", {31'h0, req_out}, 1);
        chk("b2b_data8", {24'h0, data_out}, 32'h22);
        repeat (6) @(negedge CLK);
        chk("b2b_ready14", {31'h0, in_ready}, 1);

        // slow far side, stray in_valid during the transfer
        loop = 1'b0;
        t0 = cyc;
        in_valid = 1'b1; in_data = 8'h5A;
        q.push_back('{8'h5A, t0 + 47});
        @(negedge CLK);
        in_valid = 1'b0;
        chk("slow_req1", {31'h0, req_out}, 1);
        repeat (4) @(negedge CLK);
        in_valid = 1'b1; in_data = 8'hFF;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (15) @(negedge CLK);
        ack_man = 1'b1;
        @(negedge CLK);
        chk("slow_req_a1", {31'h0, req_out}, 1);
        @(negedge CLK);
        chk("slow_req_a2", {31'h0, req_out}, 1);
        @(negedge CLK);
        chk("slow_req_a3", {31'h0, req_out}, 0);
        chk("slow_data", {24'h0, data_out}, 32'h5A);
        in_valid = 1'b1; in_data = 8'hEE;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (19) @(negedge CLK);
        ack_man = 1'b0;
        repeat (2) @(negedge CLK);
        chk("slow_ready_b2", {31'h0, in_ready}, 0);
        @(negedge CLK);
        chk("slow_ready_b3", {31'h0, in_ready}, 1);

`ifdef CDC_TX_TIMEOUT_EN
        // timeout abort with ack tied low
        t0 = cyc;
        in_valid = 1'b1; in_data = 8'h99;
        exp_err_cyc = t0 + 11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (k == 1) in_valid = 1'b0;
            chk("to_req", {31'h0, req_out}, {31'h0, k <= 10});
            chk("to_ready", {31'h0, in_ready}, {31'h0, k == 12});
        end
        // ack_s reaches 1 exactly in the limit cycle
        t0 = cyc;
        in_valid = 1'b1; in_data = 8'h66;
        q.push_back('{8'h66, t0 + 14});
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (k == 1) in_valid = 1'b0;
            if (k == 8) ack_man = 1'b1;
            if (k == 11) ack_man = 1'b0;
            chk("lim_req", {31'h0, req_out}, {31'h0, k <= 10});
        end
`endif
        loop = 1'b1;

        // asynchronous reset mid-transfer
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_req", {31'h0, req_out}, 0);
        chk("arst_data", {24'h0, data_out}, 0);
        chk("arst_done", {31'h0, done}, 0);
        chk("arst_err", {31'h0, err}, 0);
        chk("arst_ready", {31'h0, in_ready}, 1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        t0 = cyc;
        chk("post_ready", {31'h0, in_ready}, 1);
        in_valid = 1'b1; in_data = 8'h3C;
        q.push_back('{8'h3C, t0 + 7});
        @(negedge CLK);
        in_valid = 1'b0;
        chk("post_req", {31'h0, req_out}, 1);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cdc_req_tx.md
# cdc_req_tx

Source-side (transmitting) end of a four-phase req/ack clock-domain-crossing handshake. Accepts a data word from local logic via a valid/ready interface and presents it on a stable bus with a level `req_out`. It then waits for the far domain's `ack_in` before completing the return-to-zero phase. `ack_in` is asynchronous and is brought in through an internal two-flop synchronizer; the far domain synchronizes `req_out` with its own two-flop stage.

## Interface
- `WIDTH`, 8: data word width in bits.
- `TIMEOUT`, 255: maximum cycles `req_out` stays high waiting for ack (used only with `CDC_TX_TIMEOUT_EN`); legal range 2..65535.

- `CLK` input 1: single clock.
- `RST` input 1: asynchronous, active-high reset.
- `in_valid` input 1: local word available.
- `in_data` input WIDTH: local word.
- `in_ready` output 1: block can accept a word (high exactly in IDLE).
- `req_out` output 1: request level to far domain, registered.
- `data_out` output WIDTH: word to far domain, registered; stable whenever `req_out`=1.
- `ack_in` input 1: acknowledge level from far domain, asynchronous.
- `done` output 1: one-cycle pulse, transfer completed normally.
- `err` output 1: one-cycle pulse, transfer aborted by timeout (constant 0 without macro).

## Operation
- Reset (async, immediate): state IDLE, `req_out`=0, `data_out`=0, `done`=0, `err`=0, both sync flops=0, timeout counter=0.
- `ack_s` = output of the second sync flop on `ack_in`; the FSM never looks at raw `ack_in`.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture `in_data` into `data_out`, set `req_out`=1, go to REQ_HI.
  - REQ_HI: wait for `ack_s`=1, then clear `req_out` and go to REQ_LO.
  - REQ_LO: wait for `ack_s`=0, then go to IDLE and pulse `done` (suppressed if the transfer was aborted).
- `data_out` changes only on accept; holds its value through REQ_LO and IDLE until the next accept.
- `in_valid` outside IDLE is ignored; the upstream must hold the word until `in_ready`.
- `done` and `err` are registered, single-cycle, and mutually exclusive.
- Reset mid-transfer drops `req_out` immediately; the far side sees an aborted request and behaves as after a normal return-to-zero.

## Timing
- Accept sampled at the end of cycle N, giving `req_out`=1 from cycle N+1.
- Synchronizer latency: a change on `ack_in` is visible on `ack_s` two edges later.
- With far side acking immediately (`ack_in` follows `req_out`):
  - `ack_s`=1 at N+3;
  - `req_out`=0 at N+4;
  - `ack_s`=0 at N+6;
  - `done`=1 and `in_ready`=1 at N+7.
- Minimum accept-to-accept spacing is therefore 7 cycles.
- `in_ready` rises in the same cycle as `done`; an accept is legal in that cycle.

## Configuration
- `CDC_TX_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ_HI and increments each REQ_HI cycle.
  - If the counter reaches TIMEOUT−1 with `ack_s`=0, the transfer aborts: `req_out` is cleared, `err` pulses in the cycle `req_out` first reads 0, and the state moves to REQ_LO.
  - `req_out` is therefore high for exactly TIMEOUT cycles.
  - The aborted transfer returns to IDLE with no `done`.
  - `ack_s`=1 in the limit cycle wins: normal path, no `err`.
- `CDC_TX_TIMEOUT_EN` undefined:
  - No counter; REQ_HI waits indefinitely.
  - `err` is tied to 0.
  - `TIMEOUT` is ignored.

## Test plan
- Loopback `ack_in`=`req_out`, WIDTH=8, send 0xA5 at cycle 0:
  - `req_out` high at cycles 1–3;
  - `data_out`=0xA5 from cycle 1 onward;
  - `done` at cycle 7 only.
- Back-to-back: `in_valid` held high with 0x11 then 0x22 in loopback:
  - second accept at cycle 7;
  - `done` pulses at cycles 7 and 14;
  - `data_out` never changes while `req_out`=1.
- Slow far side: `ack_in` rises 20 cycles after `req_out` and falls 20 cycles after `req_out` falls:
  - `req_out` falls exactly 3 cycles after `ack_in` rises;
  - `done` comes 3 cycles after `ack_in` falls;
  - `in_valid` pulses during the transfer are ignored.
- With macro, TIMEOUT=10, `ack_in` tied 0:
  - `req_out` high for exactly 10 cycles;
  - one `err` pulse, no `done`;
  - `in_ready` returns 2 cycles after `req_out` falls.
- With macro, TIMEOUT=10, `ack_s` reaches 1 exactly in the limit cycle: normal completion, `err`=0.
- Assert `RST` asynchronously at N+2 of a transfer:
  - `req_out`, `data_out`, `done`, `err` are 0 before the next edge;
  - after release, `in_ready`=1 and a fresh transfer of 0x3C completes normally.
